// File: rtl/posit_batch_sequencer_if.sv
// Memory (s2 ports of mem0/mem1) and posit-core handshake bundle for posit_batch_sequencer.
// master = sequencer side, slave = memories + arithmetic core side.
interface posit_batch_sequencer_if #(
  parameter int POSIT_WIDTH = 32,
  parameter int ADDR_WIDTH  = 12
);
  logic [ADDR_WIDTH-1:0]  mem0_address;
  logic                   mem0_chipselect;
  logic                   mem0_clken;
  logic                   mem0_write;
  logic [7:0]             mem0_writedata;
  logic [7:0]             mem0_readdata;
  logic [ADDR_WIDTH-1:0]  mem1_address;
  logic                   mem1_chipselect;
  logic                   mem1_clken;
  logic                   mem1_write;
  logic [7:0]             mem1_writedata;
  logic [7:0]             mem1_readdata;
  logic                   op_valid;
  logic                   op_ready;
  logic [POSIT_WIDTH-1:0] num1;
  logic [POSIT_WIDTH-1:0] num2;
  logic                   res_valid;
  logic [POSIT_WIDTH-1:0] result;

  modport master (
    output mem0_address, mem0_chipselect, mem0_clken, mem0_write, mem0_writedata,
    output mem1_address, mem1_chipselect, mem1_clken, mem1_write, mem1_writedata,
    output op_valid, num1, num2,
    input  mem0_readdata, mem1_readdata, op_ready, res_valid, result
  );

  modport slave (
    input  mem0_address, mem0_chipselect, mem0_clken, mem0_write, mem0_writedata,
    input  mem1_address, mem1_chipselect, mem1_clken, mem1_write, mem1_writedata,
    input  op_valid, num1, num2,
    output mem0_readdata, mem1_readdata, op_ready, res_valid, result
  );
endinterface

// File: rtl/posit_batch_sequencer.sv
// Batch sequencer: streams posit operand pairs from mem0/mem1 through one core, writes results to mem0.
// Optional watchdog on the ISSUE/WAIT stall enabled by defining POSIT_SEQ_TIMEOUT_EN.
module posit_batch_sequencer #(
  parameter int POSIT_WIDTH    = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int MEM_RD_LAT     = 1,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  count,
  posit_batch_sequencer_if.master bus,
  output logic                  busy,
  output logic                  completed,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  done_count
);
  localparam int          B         = POSIT_WIDTH / 8;
  localparam int          FETCH_LEN = B + MEM_RD_LAT;
  localparam int          PH_W      = $clog2(FETCH_LEN + 1);
  localparam logic [63:0] MAXN      = (64'd1 << ADDR_WIDTH) / 64'(B);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t                 state_r;
  logic                   start_r, start_d_r;
  logic [CNT_WIDTH-1:0]   count_r, done_r;
  logic [ADDR_WIDTH-1:0]  base_r, addr0_r, addr1_r;
  logic [PH_W-1:0]        phase_r;
  logic                   cs0_r, cs1_r, we_r, opv_r;
  logic                   busy_r, completed_r, error_r;
  logic [7:0]             wd_r;
  logic [POSIT_WIDTH-1:0] num1_r, num2_r, res_r;
  logic                   edge_s, abort_s, timeout_s;

  // Start edge qualification and batch termination request
  always_comb begin
    edge_s  = 1'b0;
    abort_s = 1'b0;
    if (start_r && !start_d_r && !abort) begin
      edge_s = 1'b1;
    end else begin
      edge_s = 1'b0;
    end
    if (state_r != S_IDLE) begin
      abort_s = abort | timeout_s;
    end else begin
      abort_s = 1'b0;
    end
  end

`ifdef POSIT_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_r, wd_cur_s;
  state_t          wd_state_r;
  logic            stall_s;

  // Stall age: zero on the first cycle of each ISSUE/WAIT entry
  always_comb begin
    stall_s  = (state_r == S_ISSUE) || (state_r == S_WAIT);
    wd_cur_s = {WD_W{1'b0}};
    if (state_r != wd_state_r) begin
      wd_cur_s = {WD_W{1'b0}};
    end else begin
      wd_cur_s = wd_cnt_r;
    end
    timeout_s = stall_s && (wd_cur_s == WD_W'(TIMEOUT_CYCLES - 1));
  end

  // Watchdog counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt_r   <= {WD_W{1'b0}};
      wd_state_r <= S_IDLE;
    end else begin
      wd_state_r <= state_r;
      if (stall_s) begin
        wd_cnt_r <= wd_cur_s + WD_W'(1);
      end else begin
        wd_cnt_r <= {WD_W{1'b0}};
      end
    end
  end
`else
  // No watchdog: ISSUE/WAIT may stall indefinitely
  always_comb begin
    timeout_s = 1'b0;
  end
`endif

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      start_r     <= 1'b0;
      start_d_r   <= 1'b0;
      count_r     <= {CNT_WIDTH{1'b0}};
      done_r      <= {CNT_WIDTH{1'b0}};
      base_r      <= {ADDR_WIDTH{1'b0}};
      addr0_r     <= {ADDR_WIDTH{1'b0}};
      addr1_r     <= {ADDR_WIDTH{1'b0}};
      phase_r     <= {PH_W{1'b0}};
      cs0_r       <= 1'b0;
      cs1_r       <= 1'b0;
      we_r        <= 1'b0;
      opv_r       <= 1'b0;
      busy_r      <= 1'b0;
      completed_r <= 1'b0;
      error_r     <= 1'b0;
      wd_r        <= 8'h00;
      num1_r      <= {POSIT_WIDTH{1'b0}};
      num2_r      <= {POSIT_WIDTH{1'b0}};
      res_r       <= {POSIT_WIDTH{1'b0}};
    end else begin
      start_r   <= start;
      start_d_r <= start_r;
      if (abort_s) begin
        // External abort wins over the watchdog; only a timeout reports completion
        state_r     <= S_IDLE;
        busy_r      <= 1'b0;
        cs0_r       <= 1'b0;
        cs1_r       <= 1'b0;
        we_r        <= 1'b0;
        opv_r       <= 1'b0;
        error_r     <= 1'b1;
        completed_r <= timeout_s & ~abort;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (edge_s) begin
              if (64'(count) > MAXN) begin
                error_r     <= 1'b1;
                completed_r <= 1'b1;
              end else if (count == {CNT_WIDTH{1'b0}}) begin
                error_r     <= 1'b0;
                completed_r <= 1'b1;
                done_r      <= {CNT_WIDTH{1'b0}};
              end else begin
                error_r     <= 1'b0;
                completed_r <= 1'b0;
                done_r      <= {CNT_WIDTH{1'b0}};
                busy_r      <= 1'b1;
                count_r     <= count;
                base_r      <= {ADDR_WIDTH{1'b0}};
                addr0_r     <= {ADDR_WIDTH{1'b0}};
                addr1_r     <= {ADDR_WIDTH{1'b0}};
                cs0_r       <= 1'b1;
                cs1_r       <= 1'b1;
                phase_r     <= {PH_W{1'b0}};
                state_r     <= S_FETCH;
              end
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_FETCH: begin
            // Bytes arrive LSB first; shifting right leaves byte 0 at the bottom
            if (phase_r >= PH_W'(MEM_RD_LAT)) begin
              num1_r <= POSIT_WIDTH'({bus.mem0_readdata, num1_r} >> 8);
              num2_r <= POSIT_WIDTH'({bus.mem1_readdata, num2_r} >> 8);
            end else begin
              num1_r <= num1_r;
            end
            if (int'(phase_r) + 1 < B) begin
              addr0_r <= base_r + ADDR_WIDTH'(phase_r) + ADDR_WIDTH'(1);
              addr1_r <= base_r + ADDR_WIDTH'(phase_r) + ADDR_WIDTH'(1);
            end else begin
              cs0_r <= 1'b0;
              cs1_r <= 1'b0;
            end
            if (phase_r == PH_W'(FETCH_LEN - 1)) begin
              opv_r   <= 1'b1;
              state_r <= S_ISSUE;
            end else begin
              phase_r <= phase_r + PH_W'(1);
            end
          end
          S_ISSUE: begin
            if (opv_r && bus.op_ready) begin
              opv_r   <= 1'b0;
              state_r <= S_WAIT;
            end else begin
              state_r <= S_ISSUE;
            end
          end
          S_WAIT: begin
            if (bus.res_valid) begin
              wd_r    <= bus.result[7:0];
              res_r   <= bus.result >> 8;
              addr0_r <= base_r;
              cs0_r   <= 1'b1;
              we_r    <= 1'b1;
              phase_r <= {PH_W{1'b0}};
              state_r <= S_WRITE;
            end else begin
              state_r <= S_WAIT;
            end
          end
          S_WRITE: begin
            if (int'(phase_r) + 1 < B) begin
              addr0_r <= base_r + ADDR_WIDTH'(phase_r) + ADDR_WIDTH'(1);
              wd_r    <= res_r[7:0];
              res_r   <= res_r >> 8;
              phase_r <= phase_r + PH_W'(1);
            end else begin
              cs0_r   <= 1'b0;
              we_r    <= 1'b0;
              state_r <= S_NEXT;
            end
          end
          S_NEXT: begin
            done_r <= done_r + CNT_WIDTH'(1);
            if (done_r + CNT_WIDTH'(1) == count_r) begin
              state_r <= S_DONE;
            end else begin
              base_r  <= base_r + ADDR_WIDTH'(B);
              addr0_r <= base_r + ADDR_WIDTH'(B);
              addr1_r <= base_r + ADDR_WIDTH'(B);
              cs0_r   <= 1'b1;
              cs1_r   <= 1'b1;
              phase_r <= {PH_W{1'b0}};
              state_r <= S_FETCH;
            end
          end
          S_DONE: begin
            busy_r      <= 1'b0;
            completed_r <= 1'b1;
            state_r     <= S_IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            cs0_r   <= 1'b0;
            cs1_r   <= 1'b0;
            we_r    <= 1'b0;
            opv_r   <= 1'b0;
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.mem0_address    = addr0_r;
  assign bus.mem0_chipselect = cs0_r;
  assign bus.mem0_clken      = busy_r;
  assign bus.mem0_write      = we_r;
  assign bus.mem0_writedata  = wd_r;
  assign bus.mem1_address    = addr1_r;
  assign bus.mem1_chipselect = cs1_r;
  assign bus.mem1_clken      = busy_r;
  assign bus.mem1_write      = 1'b0;
  assign bus.mem1_writedata  = 8'h00;
  assign bus.op_valid        = opv_r;
  assign bus.num1            = num1_r;
  assign bus.num2            = num2_r;
  assign busy                = busy_r;
  assign completed           = completed_r;
  assign error               = error_r;
  assign done_count          = done_r;
endmodule
